// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus I-mem write port of the loader.
// slave  = the loader (consumes the stream, drives the I-mem write port).
// master = the stream source / I-mem side seen from outside the loader.
interface imem_loader_if #(
   parameter int ADDR_W = 10
) ();
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output in_data, in_valid,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Accepts a framed byte stream (SYNC, count lo/hi, 4*N little-endian data
// bytes), writes the words sequentially from word 0 and holds the CPU in
// reset until a frame completes cleanly.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte covering the count bytes and all data bytes.
module imem_loader #(
   parameter int         ADDR_W    = 10,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic            clk,
   input  logic            rst,
   imem_loader_if.slave    bus,
   output logic            cpu_rst_n,
   output logic            busy,
   output logic            done,
   output logic            error
);

   // Largest legal word count (capacity of the I-mem).
   localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_W);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CNT_LO = 3'd1,
      S_CNT_HI = 3'd2,
      S_DATA   = 3'd3,
      S_DONE   = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_ERR    = 3'd5,
      S_CSUM   = 3'd6
`else
      S_ERR    = 3'd5
`endif
   } state_e;

   // State entered once the last data word (or an empty count) is consumed.
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_e S_END = S_CSUM;
`else
   localparam state_e S_END = S_DONE;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
   // Running frame checksum: plain XOR accumulation of one byte.
   function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] b);
      return csum ^ b;
   endfunction
`endif

   state_e            state_q, state_d;
   logic [15:0]       count_q, count_d;
   logic [15:0]       word_cnt_q, word_cnt_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [23:0]       asm_q, asm_d;
   logic              in_ready_q, in_ready_d;
   logic              imem_we_q, imem_we_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]       imem_wdata_q, imem_wdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              cpu_rst_n_q, cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   logic              accept_s;
   logic [15:0]       n_s;

   assign accept_s = bus.in_valid && in_ready_q;
   // Full word count as it becomes known while the high byte is accepted.
   assign n_s      = {bus.in_data, count_q[7:0]};

   assign bus.in_ready   = in_ready_q;
   assign bus.imem_we    = imem_we_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_wdata = imem_wdata_q;
   assign cpu_rst_n      = cpu_rst_n_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = error_q;

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         count_q      <= 16'd0;
         word_cnt_q   <= 16'd0;
         byte_idx_q   <= 2'd0;
         asm_q        <= 24'd0;
         in_ready_q   <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= 32'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         cpu_rst_n_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q       <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         word_cnt_q   <= word_cnt_d;
         byte_idx_q   <= byte_idx_d;
         asm_q        <= asm_d;
         in_ready_q   <= in_ready_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
         cpu_rst_n_q  <= cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   // Next state plus frame datapath: count capture, word assembly, write issue.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      word_cnt_d   = word_cnt_q;
      byte_idx_d   = byte_idx_q;
      asm_d        = asm_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d       = csum_q;
`endif
      if (accept_s) begin
         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               // Only SYNC starts a frame; every other byte is dropped.
               if (bus.in_data == SYNC_BYTE) begin
                  state_d    = S_CNT_LO;
                  count_d    = 16'd0;
                  word_cnt_d = 16'd0;
                  byte_idx_d = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_d     = 8'd0;
`endif
               end else begin
                  state_d = state_q;
               end
            end
            S_CNT_LO: begin
               count_d = {8'd0, bus.in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d  = csum_update(csum_q, bus.in_data);
`endif
               state_d = S_CNT_HI;
            end
            S_CNT_HI: begin
               count_d = n_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d  = csum_update(csum_q, bus.in_data);
`endif
               if (n_s == 16'd0) begin
                  state_d = S_END;
               end else if ({1'b0, n_s} > CAPACITY) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = csum_update(csum_q, bus.in_data);
`endif
               if (byte_idx_q == 2'd3) begin
                  // Fourth byte completes the word; issue the write next cycle.
                  imem_we_d    = 1'b1;
                  imem_addr_d  = word_cnt_q[ADDR_W-1:0];
                  imem_wdata_d = {bus.in_data, asm_q};
                  byte_idx_d   = 2'd0;
                  word_cnt_d   = word_cnt_q + 16'd1;
                  if (word_cnt_q == (count_q - 16'd1)) begin
                     state_d = S_END;
                  end else begin
                     state_d = S_DATA;
                  end
               end else begin
                  case (byte_idx_q)
                     2'd0:    asm_d[7:0]   = bus.in_data;
                     2'd1:    asm_d[15:8]  = bus.in_data;
                     2'd2:    asm_d[23:16] = bus.in_data;
                     default: asm_d        = asm_q;
                  endcase
                  byte_idx_d = byte_idx_q + 2'd1;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (bus.in_data == csum_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ERR;
               end
            end
`endif
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Status outputs decoded from the upcoming state so they register with it.
   always_comb begin
      in_ready_d  = 1'b1;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      error_d     = 1'b0;
      cpu_rst_n_d = 1'b0;
      case (state_d)
         S_IDLE: begin
            busy_d = 1'b0;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM: begin
`else
         S_CNT_LO, S_CNT_HI, S_DATA: begin
`endif
            busy_d = 1'b1;
         end
         S_DONE: begin
            done_d      = 1'b1;
            cpu_rst_n_d = 1'b1;
         end
         S_ERR: begin
            error_d = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program writer for the RV32I core's instruction memory, replacing hierarchical ROM pokes with a real load path.
- Accepts a framed byte stream (valid/ready), assembles little-endian 32-bit instruction words, and writes them sequentially into the I-mem write port from word 0.
- Holds the CPU in reset while loading and releases it once the frame completes cleanly.

Parameters:
- ADDR_W, 10, I-mem word-address width; capacity is 2**ADDR_W words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte; a transfer happens when in_valid && in_ready at a clk edge.
- imem_we  out  1  one-cycle write strobe to I-mem.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  instruction word.
- cpu_rst_n  out  1  active-low reset to the cpu; 0 while loading or on error.
- busy  out  1  a frame is in progress.
- done  out  1  last frame loaded successfully; sticky until the next SYNC or rst.
- error  out  1  last frame aborted; sticky until the next SYNC or rst.

Behaviour:
- Frame format:
  - SYNC_BYTE
  - CNT_LO, CNT_HI: 16-bit word count N, little-endian
  - 4*N data bytes, each word little-endian (first byte = bits 7:0)
  - [checksum byte, only with the optional feature]
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_n=0, busy=0, done=0, error=0. State=IDLE, word counter=0, byte index=0.
- in_ready is 1 in every state after reset; the loader never back-pressures. It is 0 only in the cycle rst is high.
- States:
  - IDLE: drop bytes until SYNC_BYTE, then go to CNT_LO, set busy=1, clear done/error, cpu_rst_n=0.
  - CNT_LO: latch the low count byte, go to CNT_HI.
  - CNT_HI: latch the high count byte, then:
    - N=0: finish (DONE, or CSUM if enabled).
    - N>2**ADDR_W: go to ERR.
    - otherwise: go to DATA.
  - DATA: shift each byte into the word assembler at byte index 0..3.
    - On the accepted 4th byte, the next cycle shows imem_we=1 with imem_addr = word counter and imem_wdata = assembled word.
    - The word counter then increments and the byte index wraps to 0.
    - After word N-1 is written, go to DONE (or CSUM).
    - Back-to-back bytes are legal in the write-pulse cycle; the write uses its own registers.
  - DONE: busy=0, done=1, cpu_rst_n=1. A later SYNC_BYTE starts a new frame and drives cpu_rst_n=0 in the next cycle. Other bytes are dropped.
  - ERR: busy=0, error=1, cpu_rst_n=0. Only SYNC_BYTE leaves this state (same as DONE).
- Write latency: exactly 1 cycle from the 4th byte's accepting edge to imem_we high. imem_we is high for exactly one cycle per word.
- Addresses: start at 0 for every frame and increase by 1. At N=2**ADDR_W the last address is 2**ADDR_W-1 with no wrap. Writes beyond capacity are impossible because of the N check.
- Inside a frame, a SYNC_BYTE value is ordinary data; there is no resync.
- rst mid-frame: immediate return to reset values. Already-written words stay in I-mem. cpu_rst_n stays 0 until a complete frame is loaded.
- The core sees only completed frames; partial images never run.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR covers CNT_LO, CNT_HI and all data bytes.
  - After the last data word (or after CNT_HI when N=0), state CSUM accepts one byte.
  - Match goes to DONE; mismatch goes to ERR with cpu_rst_n held 0.
  - Words are still written as received.
- Not defined: no CSUM state and no XOR logic; the frame ends after the data.

Test Plan:
- Reset check: rst=1 for 3 cycles with in_valid=1 -> all outputs 0, no imem_we; after release in_ready=1 and cpu_rst_n=0.
- One-word load: A5,01,00,93,00,40,01 -> one imem_we pulse with addr 0, wdata 32'h01400093 (20971667) one cycle after the byte 01 is accepted; then done=1, cpu_rst_n=1.
- Seven-word program: N=7 with words 20971667, 1048851, 1075871923, 1147283, 4262481123, 4275143059, 4271894639, in_valid toggling randomly -> 7 pulses at addr 0..6 with exact words; done=1.
- Bad count: ADDR_W=4, A5,11,00 (N=17) -> error=1, cpu_rst_n=0, no writes; then A5,00,00 -> done=1, error=0.
- Mid-frame reset: after 2 of 4 words are written, rst=1 for 1 cycle -> busy=0, cpu_rst_n=0, done=0; a fresh full frame then loads from addr 0.
- Checksum (with IMEM_LOADER_CHECKSUM_EN): A5,01,00,93,00,40,01,D3 -> done=1. Same frame with checksum byte 00 -> error=1, cpu_rst_n=0.
